hires_trace_writer: RTL and testbench

- Downstream consumer of the decimate/pack stage.
- Takes 7-bit HIRES pixel bytes for one logic channel and writes them into Apple II HIRES display memory as a two-row trace: a high-level row and a low-level row, one column per byte.
- Computes interleaved HIRES addresses, buffers bytes in a small FIFO because the producer has no backpressure, and arbitrates writes through a req/ack memory port.

---
 rtl/logic_hamr_pkg.sv | 16 +
 rtl/hires_addr.sv | 26 ++
 rtl/hires_trace_writer.sv | 191 +++++++++++++++++++
 tb/tb_hires_trace_writer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_hamr_pkg.sv
// Shared constants for the logic-analyser HIRES display path: page bases,
// screen geometry and the trace writer state encoding.
package logic_hamr_pkg;

  localparam logic [15:0] HIRES_PAGE1 = 16'h2000;
  localparam logic [15:0] HIRES_PAGE2 = 16'h4000;
  localparam int          HIRES_ROWS  = 192;
  localparam int          HIRES_COLS  = 40;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_WR_TOP = 3'd2;
  localparam logic [2:0] ST_WR_BOT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/hires_addr.sv
// Combinational Apple II HIRES address: interleaved row layout plus column.
// Shared by the trace writer and the display clear engine.
module hires_addr
  import logic_hamr_pkg::*;
(
  input  logic        page_sel,
  input  logic [7:0]  y,
  input  logic [5:0]  col,
  output logic [15:0] addr
);

  logic [15:0] base;
  logic [15:0] line_off;
  logic [15:0] group_off;
  logic [15:0] third_off;

  always_comb begin
    base      = page_sel ? HIRES_PAGE2 : HIRES_PAGE1;
    line_off  = {3'b000, y[2:0], 10'b0};
    group_off = {6'b0, y[5:3], 7'b0};
    // Each third of the screen starts 40 bytes further into the 128-byte group.
    third_off = 16'(y[7:6]) * 16'd40;
    addr      = base + line_off + group_off + third_off + {10'b0, col};
  end

endmodule

// File: rtl/hires_trace_writer.sv
// Writes one logic channel as a two-row HIRES trace: the byte on the top row,
// its inverse on the bottom row, buffered through a small FIFO.
module hires_trace_writer
  import logic_hamr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TRACE_H    = 8,
  parameter int COLS       = HIRES_COLS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        page_sel,
  input  logic [7:0]  top_row,
  input  logic [6:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        cfg_err
);

  localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [5:0]       LAST_COL = 6'(COLS);
  localparam logic [7:0]       TOP_MAX  = 8'(HIRES_ROWS - TRACE_H);
  localparam logic [7:0]       ROW_SPAN = 8'(TRACE_H - 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       col_q, col_d;
  logic             page_q, page_d;
  logic [7:0]       top_q, top_d;
  logic [6:0]       hold_q, hold_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             cfg_err_q, cfg_err_d;

  logic [6:0]       fifo_mem [FIFO_DEPTH];
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty, in_trace;
  logic [7:0]       bot_row;
  logic [15:0]      addr_top, addr_bot;

  assign bot_row = top_q + ROW_SPAN;

  hires_addr u_addr_top (
    .page_sel (page_q),
    .y        (top_q),
    .col      (col_q),
    .addr     (addr_top)
  );

  hires_addr u_addr_bot (
    .page_sel (page_q),
    .y        (bot_row),
    .col      (col_q),
    .addr     (addr_bot)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d    = state_q;
    col_d      = col_q;
    page_d     = page_q;
    top_d      = top_q;
    hold_d     = hold_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    cfg_err_d  = cfg_err_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    in_trace   = (state_q == ST_WAIT) || (state_q == ST_WR_TOP) || (state_q == ST_WR_BOT);

    if (start) begin
      // Start wins over everything else: a byte or ack in the same cycle is dropped.
      col_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      if (top_row > TOP_MAX) begin
        cfg_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cfg_err_d = 1'b0;
        page_d    = page_sel;
        top_d     = top_row;
        state_d   = ST_WAIT;
      end
    end else begin
      fifo_pop = (state_q == ST_WAIT) && !fifo_empty;
      if (byte_valid && in_trace) begin
        if (!fifo_full || fifo_pop) fifo_push = 1'b1;
        else                        overflow_d = 1'b1;
      end

      case (state_q)
        ST_WAIT: begin
          if (fifo_pop) begin
            hold_d  = fifo_mem[rd_ptr_q];
            state_d = ST_WR_TOP;
          end
        end
        ST_WR_TOP: if (mem_ack) state_d = ST_WR_BOT;
        ST_WR_BOT: begin
          if (mem_ack) begin
            col_d   = col_q + 6'd1;
            state_d = (col_d == LAST_COL) ? ST_DONE : ST_WAIT;
          end
        end
        default: ;
      endcase

      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      page_q     <= 1'b0;
      top_q      <= '0;
      hold_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      page_q     <= page_d;
      top_q      <= top_d;
      hold_q     <= hold_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count gates every read so stale data is never used.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= byte_in;
  end

  always_comb begin
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (state_q)
      ST_WR_TOP: begin
        mem_wr   = 1'b1;
        mem_addr = addr_top;
        mem_data = {1'b0, hold_q};
      end
      ST_WR_BOT: begin
        mem_wr   = 1'b1;
        mem_addr = addr_bot;
        mem_data = {1'b0, ~hold_q};
      end
      default: ;
    endcase
  end

  assign busy     = in_trace;
  assign done     = (state_q == ST_DONE);
  assign overflow = overflow_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_hires_trace_writer.sv
// Directed self-checking bench for hires_trace_writer; expected addresses are
// hand-derived from the interleaved HIRES layout.
module tb_hires_trace_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        page_sel;
  logic [7:0]  top_row;
  logic [6:0]  byte_in;
  logic        byte_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  hires_trace_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .page_sel   (page_sel),
    .top_row    (top_row),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic p, input logic [7:0] r);
    page_sel = p;
    top_row  = r;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [6:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic wait_wr(input string tag);
    int t = 0;
    while (!mem_wr && t < 50) begin
      step();
      t++;
    end
    check({tag, "_timeout"}, {31'b0, mem_wr}, 32'd1);
  endtask

  // Assumes mem_ack is high: the write completes at the next edge.
  task automatic expect_write(input string tag, input logic [15:0] a, input logic [7:0] d);
    wait_wr(tag);
    check({tag, "_addr"}, {16'b0, mem_addr}, {16'b0, a});
    check({tag, "_data"}, {24'b0, mem_data}, {24'b0, d});
    step();
  endtask

  task automatic expect_no_write(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      step();
      if (mem_wr) seen = 1'b1;
    end
    check(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    logic [6:0] b;
    logic       moved;
    rst_n      = 1'b0;
    start      = 1'b0;
    page_sel   = 1'b0;
    top_row    = 8'd0;
    byte_in    = 7'd0;
    byte_valid = 1'b0;
    mem_ack    = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_flags", {27'b0, mem_wr, busy, done, overflow, cfg_err}, 32'd0);
    check("rst_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_data", {24'b0, mem_data}, 32'd0);

    // Address check: page 1, rows 0 and 7
    mem_ack = 1'b1;
    do_start(1'b0, 8'd0);
    check("a_busy", {31'b0, busy}, 32'd1);
    send_byte(7'h55);
    expect_write("a_top", 16'h2000, 8'h55);
    expect_write("a_bot", 16'h3C00, 8'h2A);
    check("a_back_wait", {29'b0, mem_wr, busy, done}, 32'b010);

    // Interleave check: page 2, rows 184 and 191
    do_start(1'b1, 8'd184);
    send_byte(7'h7F);
    expect_write("i_top", 16'h43D0, 8'h7F);
    expect_write("i_bot", 16'h5FD0, 8'h00);

    // Full row of 40 columns on rows 0/7
    do_start(1'b0, 8'd0);
    for (int i = 1; i <= 40; i++) begin
      b = 7'(i);
      send_byte(b);
      expect_write($sformatf("f_top%0d", i), 16'h2000 + 16'(i - 1), {1'b0, b});
      expect_write($sformatf("f_bot%0d", i), 16'h3C00 + 16'(i - 1), {1'b0, ~b});
    end
    check("f_done", {30'b0, done, busy}, 32'b10);
    send_byte(7'h29);
    expect_no_write("f_no_41st", 10);
    check("f_done_hold", {31'b0, done}, 32'd1);

    // Backpressure: ack low, six bytes every 7 cycles, depth-4 FIFO
    mem_ack = 1'b0;
    do_start(1'b0, 8'd8);
    moved = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_byte(7'h11 + 7'(i));
      repeat (6) begin
        if (mem_wr && (mem_addr !== 16'h2080 || mem_data !== 8'h11)) moved = 1'b1;
        step();
      end
    end
    repeat (8) begin
      if (mem_wr && (mem_addr !== 16'h2080 || mem_data !== 8'h11)) moved = 1'b1;
      step();
    end
    check("b_stable", {31'b0, moved}, 32'd0);
    check("b_stalled", {31'b0, mem_wr}, 32'd1);
    check("b_overflow", {31'b0, overflow}, 32'd1);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 7'h11 + 7'(i);
      expect_write($sformatf("b_top%0d", i), 16'h2080 + 16'(i), {1'b0, b});
      expect_write($sformatf("b_bot%0d", i), 16'h3C80 + 16'(i), {1'b0, ~b});
    end
    expect_no_write("b_dropped", 10);

    // Abort mid-WR_TOP with ack low; overflow is still set from above
    mem_ack = 1'b0;
    send_byte(7'h33);
    wait_wr("ab_pre");
    send_byte(7'h44);
    do_start(1'b1, 8'd100);
    check("ab_wr_drop", {31'b0, mem_wr}, 32'd0);
    check("ab_ovf_clr", {30'b0, overflow, busy}, 32'b01);
    expect_no_write("ab_fifo_empty", 10);
    mem_ack = 1'b1;
    send_byte(7'h5A);
    expect_write("ab_top", 16'h5228, 8'h5A);
    expect_write("ab_bot", 16'h4EA8, 8'h25);

    // Config error: top_row 190 leaves no room for an 8-row trace
    do_start(1'b0, 8'd190);
    check("c_err", {30'b0, cfg_err, busy}, 32'b10);
    send_byte(7'h12);
    expect_no_write("c_no_write", 10);

    // Reset mid-trace
    mem_ack = 1'b0;
    do_start(1'b0, 8'd0);
    check("c_err_clr", {31'b0, cfg_err}, 32'd0);
    send_byte(7'h3C);
    wait_wr("r_pre");
    rst_n = 1'b0;
    step();
    check("r_flags", {27'b0, mem_wr, busy, done, overflow, cfg_err}, 32'd0);
    check("r_addr", {16'b0, mem_addr}, 32'd0);
    check("r_data", {24'b0, mem_data}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
